// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types: word width, NOP encoding, default boot PC and the
// {pc, instr} record that travels through the prefetch buffer.
package rv32_pkg;

   localparam int               XLEN             = 32;
   localparam logic [XLEN-1:0]  RV_NOP           = 32'h0000_0013;
   localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, redirect request and the
// downstream valid/ready instruction channel.
interface fetch_unit_if #(
   parameter int XLEN = rv32_pkg::XLEN
);

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc4;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
      input  imem_rdata, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
      output imem_rdata, redirect, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small circular prefetch buffer of fetch entries; flush beats push, and the
// slots reset to zero so an empty buffer presents a clean head.
module fetch_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t rdata_o,
   output logic [CW-1:0] count_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign count_d = count_q + CW'(push_i) - CW'(pop_i);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
         count_q <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            mem_q[gi] <= '0;
         else if (push_i && !flush_i && wr_ptr_q == PW'(gi))
            mem_q[gi] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency memory reads
// under a credit limit and hands {instr, pc, pc+4} downstream.
module fetch_unit
   import rv32_pkg::*;
#(
   parameter int              XLEN     = rv32_pkg::XLEN,  // must match the package entry width
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);

   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] issued_pc_q, issued_pc_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] target_pc, req_addr;
   logic            issue, pop, push;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;
   logic            fifo_empty, fifo_full_unused;
   fetch_entry_t    push_entry, head_entry;

   assign target_pc = bus.redirect_pc & ~XLEN'(3);

   // A redirect hides the head so nothing stale is consumed in the flush cycle.
   assign bus.out_valid = ~fifo_empty & ~bus.redirect;
   assign pop           = bus.out_valid & bus.out_ready;
   assign push          = inflight_q & ~bus.redirect;

   // Buffered + in flight + the new request must fit after this cycle's pop,
   // so every response always has a free slot waiting for it.
   assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue       = reset & (bus.redirect | (credit_used < (CW+1)'(DEPTH)));
   assign req_addr    = bus.redirect ? target_pc : fetch_pc_q;

   assign bus.imem_req  = issue;
   assign bus.imem_addr = req_addr;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      issued_pc_d = issued_pc_q;
      inflight_d  = issue;
      if (issue) begin
         fetch_pc_d  = req_addr + PC_STEP;
         issued_pc_d = req_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q  <= RESET_PC;
         issued_pc_q <= RESET_PC;
         inflight_q  <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         issued_pc_q <= issued_pc_d;
         inflight_q  <= inflight_d;
      end
   end

   assign push_entry.pc    = issued_pc_q;
   assign push_entry.instr = bus.imem_rdata;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.redirect),
      .wdata_i (push_entry),
      .rdata_o (head_entry),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full_unused)
   );

   assign bus.out_instr = head_entry.instr;
   assign bus.out_pc    = head_entry.pc;
   assign bus.out_pc4   = head_entry.pc + PC_STEP;

endmodule
